dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of both requesters and the memory port.
REQ-003 Port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1, reset; it SHALL be synchronous and active-high.
REQ-005 Ports mN_req_i, input, 1, request from requester N; N=0 is the pipeline MEM stage and N=1 is the loader/debug port.
REQ-006 Ports mN_we_i, input, 1, write request from requester N; 0 means a read.
REQ-007 Ports mN_addr_i, input, ADDR_W, access address from requester N.
REQ-008 Ports mN_wdata_i, input, DATA_W, write data from requester N.
REQ-009 Ports mN_gnt_o, output, 1, one-cycle pulse; the command was accepted.
REQ-010 Ports mN_ack_o, output, 1, one-cycle pulse; the access is complete.
REQ-011 Ports mN_rdata_o, output, DATA_W, read result, valid while mN_ack_o is high for a read.
REQ-012 Ports mem_addr_o (ADDR_W) and mem_wdata_o (DATA_W), outputs, command to the data memory.
REQ-013 Ports mem_we_o and mem_re_o, outputs, 1, memory write strobe and read strobe.
REQ-014 Port mem_rdata_i, input, DATA_W, combinational read data returned by the memory.

Function
REQ-015 The FSM SHALL have three states, IDLE, ACC and RESP, and SHALL step IDLE -> ACC -> RESP -> IDLE.
REQ-016 In IDLE with any mN_req_i high, the block SHALL select a winner, register its we/addr/wdata, pulse the winner's mN_gnt_o in that same cycle, and go to ACC.
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-018 In ACC, mem_addr_o and mem_wdata_o SHALL be driven from the registered command.
REQ-019 In ACC, exactly one of mem_we_o or mem_re_o SHALL be high, for exactly one cycle; all of mem_* SHALL be 0 in every other state.
REQ-020 In RESP, the block SHALL capture mem_rdata_i into the winner's mN_rdata_o on a read, pulse the winner's mN_ack_o, and return to IDLE.
REQ-021 Latency SHALL be: gnt in cycle T, memory strobe in T+1, ack in T+2; the next grant is no earlier than T+3.
REQ-022 A requester SHALL hold req and its command stable until it sees gnt, and SHALL drop req in the cycle after gnt unless it is issuing a new request.
REQ-023 A req that arrives while the FSM is in ACC or RESP SHALL wait; it SHALL NOT be lost.
REQ-024 mN_rdata_o SHALL hold its last value until that requester's next read completes; writes SHALL NOT change it.
REQ-025 Addresses SHALL be forwarded unmodified; the arbiter SHALL NOT range-check them.
REQ-026 The loser's gnt and ack SHALL stay 0 throughout an access.

Reset
REQ-027 While rst_i is high at a clock edge, the FSM SHALL go to IDLE, and all outputs, the rdata registers and the command registers SHALL be cleared to 0.
REQ-028 The priority pointer SHALL reset so that m0 wins the first contention.
REQ-029 On reset during ACC or RESP, the access SHALL be abandoned with no ack; a write already strobed in ACC stays committed.

Configuration
REQ-030 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on contention in IDLE the requester that did not win the last grant SHALL win, and the pointer SHALL update on every grant.
REQ-031 Without DMEM_ARB_RR_EN, arbitration SHALL be fixed priority with m0 always winning, and the pointer logic SHALL be absent.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the state enum (IDLE/ACC/RESP) and the default ADDR_W/DATA_W constants.
REQ-033 The two-way winner selection (fixed or round-robin) SHALL be a sub-module, arb2_pick; the FSM and datapath stay in dmem_arbiter.

Verification
REQ-034 The bench SHALL cover each scenario below:
- m0 read addr 0x10, memory returns 0xDEADBEEF -> m0_gnt in T, mem_re_o in T+1, m0_ack with m0_rdata_o=0xDEADBEEF in T+2.
- m1 write addr 0x04 data 0x12345678 -> mem_we_o high exactly one cycle with that addr/data; m1_ack in T+2; m1_rdata_o unchanged.
- m0 and m1 both requesting continuously with DMEM_ARB_RR_EN -> grants alternate m0, m1, m0, m1 every 3 cycles.
- Same stimulus without the macro -> m0 granted every 3 cycles; m1 never granted.
- m1 raises req while m0 is in ACC -> m1_gnt in the cycle after m0_ack.
- rst_i asserted during RESP -> no ack; all outputs 0 next cycle; the first later contention goes to m0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared state encoding and default widths for the data-memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACC  = ST_ACC,
        RESP = ST_RESP
    } state_e;

endpackage

`default_nettype wire

// File: rtl/arb2_pick.sv
// ============================================================================
// Module : arb2_pick
// Brief  : Two-way winner selection; round-robin when DMEM_ARB_RR_EN is
//          defined, otherwise fixed priority with requester 0 on top.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb2_pick (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       any_o,
    output logic       win_o
);

    assign any_o = |req_i;

`ifdef DMEM_ARB_RR_EN
    // r_last remembers the previous winner; reset value makes m0 win first.
    logic r_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (take_i) begin
            r_last <= win_o;
        end
    end

    assign win_o = (&req_i) ? ~r_last : req_i[1];
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk_i, rst_i, take_i};

    assign win_o = ~req_i[0];
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Two-requester arbiter for a single data-memory port. One access
//          at a time: grant, memory strobe, ack. Macro DMEM_ARB_RR_EN selects
//          round-robin arbitration (default build is fixed priority).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            r_state;
    logic              r_who;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic w_any;
    logic w_win;
    logic w_take;
    logic w_acc;
    logic w_ack;

    assign w_take = (r_state == IDLE) && w_any && !rst_i;
    assign w_acc  = (r_state == ACC);
    // Reset in RESP abandons the access, so the ack must not escape that cycle.
    assign w_ack  = (r_state == RESP) && !rst_i;

    arb2_pick u_pick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  ({m1_req_i, m0_req_i}),
        .take_i (w_take),
        .any_o  (w_any),
        .win_o  (w_win)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_who    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= ACC;
                        r_who   <= w_win;
                        r_we    <= w_win ? m1_we_i    : m0_we_i;
                        r_addr  <= w_win ? m1_addr_i  : m0_addr_i;
                        r_wdata <= w_win ? m1_wdata_i : m0_wdata_i;
                    end
                end
                ACC: begin
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                    if (!r_we) begin
                        if (r_who) begin
                            r_rdata1 <= mem_rdata_i;
                        end else begin
                            r_rdata0 <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m0_gnt_o = w_take && !w_win;
    assign m1_gnt_o = w_take &&  w_win;
    assign m0_ack_o = w_ack && !r_who;
    assign m1_ack_o = w_ack &&  r_who;

    // Read data arrives during RESP; pass it through so it is valid with ack.
    assign m0_rdata_o = (m0_ack_o && !r_we) ? mem_rdata_i : r_rdata0;
    assign m1_rdata_o = (m1_ack_o && !r_we) ? mem_rdata_i : r_rdata1;

    assign mem_addr_o  = w_acc ? r_addr  : '0;
    assign mem_wdata_o = w_acc ? r_wdata : '0;
    assign mem_we_o    = w_acc &&  r_we;
    assign mem_re_o    = w_acc && !r_we;

endmodule

`default_nettype wire
